intl_writeback: RTL and testbench
=================================

Name: intl_writeback

Overview:
- Downstream neighbour of the integer logic unit. Captures its result (ResData, Condition) together with the destination register tag and valid from issue.
- Squashes not-taken conditional moves and writes to R31 (hardwired zero register).
- Buffers surviving results in a small in-order FIFO.
- Drains the FIFO to the shared register-file write port under a request/grant handshake, because other execution units arbitrate for the same port.

Parameters:
- Q, 64, datapath width (quadword).
- RA, 5, register address width.
- DEPTH, 4, writeback FIFO entries (power of two, >=2).
- CW, 8, width of the saturating squash counter.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- iValid  input  1  a result from the logic unit is presented this cycle.
- iData  input  Q  result data (ResData of logic unit).
- iCond  input  1  condition (Condition of logic unit); 0 = cmov not taken.
- iDest  input  RA  destination register number.
- oReady  output  1  FIFO can accept a result this cycle.
- wr_req  output  1  register-file write request.
- wr_addr  output  RA  write address (head entry).
- wr_data  output  Q  write data (head entry).
- wr_gnt  input  1  arbiter grant; write happens when wr_req & wr_gnt.
- oCount  output  log2(DEPTH)+1  current occupancy.
- oSquash  output  CW  number of squashed results, saturating.
- oOvf  output  1  sticky: a push was attempted while full.

Behaviour:
- Reset (async, immediate): FIFO empty, read/write pointers 0, oCount=0, oSquash=0, oOvf=0, wr_req=0, wr_addr=0, wr_data=0, oReady=1.
- Accept condition: accept = iValid & oReady & iCond & (iDest != 31).
- Squash condition: squash = iValid & oReady & (~iCond | iDest==31). A squashed result is not enqueued; oSquash increments by 1 and holds at 2^CW-1 (no wrap).
- oReady = (oCount != DEPTH). It does not depend on a same-cycle pop; there is no full pass-through.
- Overflow: iValid while oReady=0 sets oOvf=1 (sticky until reset). The result is dropped and oSquash is unchanged.
- Push: on accept, entry {iDest, iData} is written at the write pointer and the pointer advances modulo DEPTH. The entry is visible on wr_* in the next cycle when the FIFO was empty, so minimum latency input->wr_req is 1 cycle.
- Drain outputs: wr_req = (oCount != 0). wr_addr/wr_data are driven combinationally from the head entry. When empty, wr_addr=0 and wr_data=0.
- Pop: on wr_req & wr_gnt, the read pointer advances modulo DEPTH at the posedge. wr_req stays asserted with stable wr_addr/wr_data until granted; there is no timeout. wr_gnt while wr_req=0 is ignored.
- Simultaneous push and pop: oCount is unchanged and both pointers advance.
- Pointer wrap: after DEPTH pushes the pointers wrap. Order is strictly FIFO across the wrap.
- Squash with a simultaneous pop: the pop still occurs and oCount decrements.
- Reset mid-drain: all entries are discarded immediately and wr_req deasserts combinationally with reset.
- No register-file forwarding in this block; a consumer that needs bypass reads oCount/wr_* externally.

Test Plan:
- Basic pass: reset, then iValid=1, iCond=1, iDest=3, iData=64'h00FF00FF00FF00FF with wr_gnt=1 constant. Required: next cycle wr_req=1, wr_addr=3, wr_data=64'h00FF00FF00FF00FF; one cycle later oCount=0 and wr_req=0.
- Squash: iValid with iCond=0, iDest=5, then iValid with iCond=1, iDest=31. Required: wr_req never asserts and oSquash=2. Drive 300 further squashes: oSquash holds at 255.
- Fill/overflow: wr_gnt=0, push 5 results with dests 1..5. Required: oCount=4, oReady=0, oOvf=1. Then wr_gnt=1: writes appear to addrs 1,2,3,4 on consecutive cycles and dest 5 is never written.
- Backpressure hold: one entry (dest 7, data 64'hDEAD), wr_gnt=0 for 3 cycles. Required: wr_req=1 with wr_addr=7, wr_data=64'hDEAD stable all 3 cycles; popped on the first wr_gnt=1.
- Simultaneous push/pop with wrap: keep 2 entries resident, then push and grant every cycle for 10 cycles with dests 10..19. Required: oCount stays 2 and write order is exact (old two, then 10..17).
- Async reset mid-drain: 3 entries queued, assert reset between clock edges. Required: wr_req=0, oCount=0, oOvf=0, oSquash=0 immediately, before the next posedge.

Source files
------------

// File: rtl/intl_writeback_if.sv
`default_nettype none
//==============================================================================
// Module   : intl_writeback_if
// Desc     : Logic-unit result capture and register-file write-port bundle.
// Revision : 1.0 - initial release
//==============================================================================
interface intl_writeback_if #(
  parameter int Q     = 64,
  parameter int RA    = 5,
  parameter int DEPTH = 4,
  parameter int CW    = 8
);
  logic                     iValid;
  logic [Q-1:0]             iData;
  logic                     iCond;
  logic [RA-1:0]            iDest;
  logic                     oReady;
  logic                     wr_req;
  logic [RA-1:0]            wr_addr;
  logic [Q-1:0]             wr_data;
  logic                     wr_gnt;
  logic [$clog2(DEPTH):0]   oCount;
  logic [CW-1:0]            oSquash;
  logic                     oOvf;

  // Upstream producer, write-port arbiter and status observer side
  modport master (
    output iValid, iData, iCond, iDest, wr_gnt,
    input  oReady, wr_req, wr_addr, wr_data, oCount, oSquash, oOvf
  );

  modport slave (
    input  iValid, iData, iCond, iDest, wr_gnt,
    output oReady, wr_req, wr_addr, wr_data, oCount, oSquash, oOvf
  );
endinterface
`default_nettype wire

// File: rtl/intl_writeback.sv
`default_nettype none
//==============================================================================
// Module   : intl_writeback
// Desc     : Squashes dead logic-unit results, buffers the rest in order and
//            drains them to the shared register-file write port.
// Revision : 1.0 - initial release
//==============================================================================
module intl_writeback #(
  parameter int Q     = 64,
  parameter int RA    = 5,
  parameter int DEPTH = 4,
  parameter int CW    = 8
) (
  input  wire logic        clk,
  input  wire logic        reset,
  intl_writeback_if.slave  bus
);
  localparam int            c_AW       = $clog2(DEPTH);
  localparam logic [c_AW:0] c_FULL     = (c_AW + 1)'(DEPTH);
  localparam logic [RA-1:0] c_ZERO_REG = RA'(31);

  logic [RA+Q-1:0] r_mem [DEPTH];
  logic [c_AW-1:0] r_wrPtr;
  logic [c_AW-1:0] r_rdPtr;
  logic [c_AW:0]   r_count;
  logic [CW-1:0]   r_squash;
  logic            r_ovf;

  logic            w_ready;
  logic            w_isZeroReg;
  logic            w_accept;
  logic            w_squash;
  logic            w_req;
  logic            w_pop;
  logic [RA+Q-1:0] w_head;

  // Readiness is occupancy-only so the upstream never sees a same-cycle pop
  assign w_ready     = (r_count != c_FULL);
  assign w_isZeroReg = (bus.iDest == c_ZERO_REG);
  assign w_accept    = bus.iValid & w_ready & bus.iCond & ~w_isZeroReg;
  assign w_squash    = bus.iValid & w_ready & (~bus.iCond | w_isZeroReg);
  assign w_req       = (r_count != '0);
  assign w_pop       = w_req & bus.wr_gnt;
  assign w_head      = w_req ? r_mem[r_rdPtr] : '0;

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_wrPtr] <= {bus.iDest, bus.iData};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrPtr  <= '0;
      r_rdPtr  <= '0;
      r_count  <= '0;
      r_squash <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wrPtr <= r_wrPtr + c_AW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + c_AW'(1);
      end
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + (c_AW + 1)'(1);
        2'b01:   r_count <= r_count - (c_AW + 1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_squash && (r_squash != '1)) begin
        r_squash <= r_squash + CW'(1);
      end
      if (bus.iValid && !w_ready) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign bus.oReady  = w_ready;
  assign bus.wr_req  = w_req;
  assign bus.wr_addr = w_head[RA+Q-1:Q];
  assign bus.wr_data = w_head[Q-1:0];
  assign bus.oCount  = r_count;
  assign bus.oSquash = r_squash;
  assign bus.oOvf    = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_intl_writeback.sv
`default_nettype none
//==============================================================================
// Module   : tb_intl_writeback
// Desc     : Scoreboard bench for intl_writeback: expected writes are queued as
//            results are driven and compared as the write port drains them.
// Revision : 1.0 - initial release
//==============================================================================
module tb_intl_writeback;
  localparam int Q     = 64;
  localparam int RA    = 5;
  localparam int DEPTH = 4;
  localparam int CW    = 8;

  typedef logic [RA+Q-1:0] entry_t;

  logic   clk;
  logic   reset;
  int     tests;
  int     fails;
  entry_t sb[$];

  intl_writeback_if #(.Q(Q), .RA(RA), .DEPTH(DEPTH), .CW(CW)) bus ();

  intl_writeback #(.Q(Q), .RA(RA), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // A write commits at the next posedge whenever req & gnt hold mid-cycle
  always @(negedge clk) begin
    if (!reset && bus.wr_req && bus.wr_gnt) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write",
                 bus.wr_addr, bus.wr_data);
      end else begin
        entry_t exp;
        exp = sb.pop_front();
        if ({bus.wr_addr, bus.wr_data} !== exp) begin
          fails++;
          $display("FAIL write_order: got addr=%0d data=%h, expected addr=%0d data=%h",
                   bus.wr_addr, bus.wr_data, exp[RA+Q-1:Q], exp[Q-1:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.iValid = 1'b0;
    bus.iCond  = 1'b0;
    bus.iDest  = '0;
    bus.iData  = '0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    sb.delete();
    reset = 1'b0;
    tick();
  endtask

  task automatic drive(input logic cond, input logic [RA-1:0] dest, input logic [Q-1:0] data);
    bus.iValid = 1'b1;
    bus.iCond  = cond;
    bus.iDest  = dest;
    bus.iData  = data;
  endtask

  task automatic check_sb_empty(input string name);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL %s: %0d expected writes never appeared, required 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.wr_gnt = 1'b0;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
    tick();
    tests++;
    if ({bus.oCount, bus.wr_req, bus.oReady, bus.oOvf} !== {3'd0, 1'b0, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL reset_flags: count=%0d req=%b ready=%b ovf=%b, required 0 0 1 0",
               bus.oCount, bus.wr_req, bus.oReady, bus.oOvf);
    end
    tests++;
    if ({bus.wr_addr, bus.wr_data, bus.oSquash} !== '0) begin
      fails++;
      $display("FAIL reset_data: addr=%0d data=%h squash=%0d, required all 0",
               bus.wr_addr, bus.wr_data, bus.oSquash);
    end
  endtask

  task automatic test_basic();
    bus.wr_gnt = 1'b1;
    drive(1'b1, 5'd3, 64'h00FF00FF00FF00FF);
    sb.push_back({5'd3, 64'h00FF00FF00FF00FF});
    tick();
    idle_inputs();
    tests++;
    if ({bus.wr_req, bus.wr_addr, bus.wr_data} !== {1'b1, 5'd3, 64'h00FF00FF00FF00FF}) begin
      fails++;
      $display("FAIL basic_latency: req=%b addr=%0d data=%h, required 1 3 00ff00ff00ff00ff",
               bus.wr_req, bus.wr_addr, bus.wr_data);
    end
    tick();
    tests++;
    if (bus.oCount !== 3'd0 || bus.wr_req !== 1'b0) begin
      fails++;
      $display("FAIL basic_drain: count=%0d req=%b, required 0 0", bus.oCount, bus.wr_req);
    end
    check_sb_empty("basic_sb");
  endtask

  task automatic test_squash();
    int reqSeen;
    reqSeen = 0;
    bus.wr_gnt = 1'b0;
    drive(1'b0, 5'd5, 64'h1111);
    tick();
    if (bus.wr_req) reqSeen++;
    drive(1'b1, 5'd31, 64'h2222);
    tick();
    if (bus.wr_req) reqSeen++;
    idle_inputs();
    tick();
    if (bus.wr_req) reqSeen++;
    tests++;
    if (reqSeen != 0) begin
      fails++;
      $display("FAIL squash_no_req: wr_req high on %0d cycles, required 0", reqSeen);
    end
    tests++;
    if (bus.oSquash !== 8'd2) begin
      fails++;
      $display("FAIL squash_count: got %0d, required 2", bus.oSquash);
    end
    for (int i = 0; i < 300; i++) begin
      drive(1'b0, RA'(i % 31), Q'(i));
      tick();
      if (i == 252) begin
        tests++;
        if (bus.oSquash !== 8'd255) begin
          fails++;
          $display("FAIL squash_reach_max: got %0d, required 255", bus.oSquash);
        end
      end
    end
    idle_inputs();
    tick();
    tests++;
    if (bus.oSquash !== 8'd255) begin
      fails++;
      $display("FAIL squash_saturate: got %0d, required 255", bus.oSquash);
    end
  endtask

  task automatic test_fill_overflow();
    apply_reset();
    bus.wr_gnt = 1'b0;
    for (int d = 1; d <= 5; d++) begin
      drive(1'b1, RA'(d), 64'hA000_0000_0000_0000 | Q'(d));
      if (d <= DEPTH) sb.push_back({RA'(d), 64'hA000_0000_0000_0000 | Q'(d)});
      tick();
      if (d == 4) begin
        tests++;
        if (bus.oReady !== 1'b0 || bus.oOvf !== 1'b0) begin
          fails++;
          $display("FAIL fill_full: ready=%b ovf=%b, required 0 0", bus.oReady, bus.oOvf);
        end
      end
    end
    idle_inputs();
    tests++;
    if ({bus.oCount, bus.oReady, bus.oOvf} !== {3'd4, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL overflow_flags: count=%0d ready=%b ovf=%b, required 4 0 1",
               bus.oCount, bus.oReady, bus.oOvf);
    end
    tests++;
    if (bus.oSquash !== 8'd0) begin
      fails++;
      $display("FAIL overflow_squash: got %0d, required 0", bus.oSquash);
    end
    bus.wr_gnt = 1'b1;
    for (int d = 1; d <= 4; d++) begin
      tests++;
      if (bus.wr_req !== 1'b1 || bus.wr_addr !== RA'(d)) begin
        fails++;
        $display("FAIL drain_consecutive: req=%b addr=%0d, required 1 %0d",
                 bus.wr_req, bus.wr_addr, d);
      end
      tick();
    end
    tests++;
    if (bus.wr_req !== 1'b0 || bus.oCount !== 3'd0) begin
      fails++;
      $display("FAIL drain_done: req=%b count=%0d, required 0 0", bus.wr_req, bus.oCount);
    end
    check_sb_empty("fill_sb");
    bus.wr_gnt = 1'b0;
  endtask

  task automatic test_backpressure();
    bus.wr_gnt = 1'b0;
    drive(1'b1, 5'd7, 64'hDEAD);
    sb.push_back({5'd7, 64'hDEAD});
    tick();
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      tests++;
      if ({bus.wr_req, bus.wr_addr, bus.wr_data} !== {1'b1, 5'd7, 64'hDEAD}) begin
        fails++;
        $display("FAIL hold_stable: cycle %0d req=%b addr=%0d data=%h, required 1 7 dead",
                 c, bus.wr_req, bus.wr_addr, bus.wr_data);
      end
      tick();
    end
    bus.wr_gnt = 1'b1;
    tick();
    bus.wr_gnt = 1'b0;
    tests++;
    if (bus.oCount !== 3'd0 || bus.wr_req !== 1'b0) begin
      fails++;
      $display("FAIL hold_pop: count=%0d req=%b, required 0 0", bus.oCount, bus.wr_req);
    end
    check_sb_empty("hold_sb");
  endtask

  task automatic test_back_to_back();
    int badCount;
    badCount = 0;
    bus.wr_gnt = 1'b0;
    for (int d = 8; d <= 9; d++) begin
      drive(1'b1, RA'(d), 64'hB0B0_0000_0000_0000 | Q'(d));
      sb.push_back({RA'(d), 64'hB0B0_0000_0000_0000 | Q'(d)});
      tick();
    end
    for (int d = 10; d <= 19; d++) begin
      drive(1'b1, RA'(d), 64'hC0C0_0000_0000_0000 | Q'(d * 3));
      sb.push_back({RA'(d), 64'hC0C0_0000_0000_0000 | Q'(d * 3)});
      bus.wr_gnt = 1'b1;
      tick();
      if (bus.oCount !== 3'd2) badCount++;
    end
    idle_inputs();
    tests++;
    if (badCount != 0) begin
      fails++;
      $display("FAIL pushpop_count: occupancy left 2 on %0d cycles, required 0", badCount);
    end
    tick();
    tick();
    bus.wr_gnt = 1'b0;
    tests++;
    if (bus.oCount !== 3'd0) begin
      fails++;
      $display("FAIL pushpop_drain: count=%0d, required 0", bus.oCount);
    end
    check_sb_empty("pushpop_sb");
  endtask

  task automatic test_async_reset();
    bus.wr_gnt = 1'b0;
    drive(1'b0, 5'd2, 64'h5);
    tick();
    for (int d = 20; d < 23; d++) begin
      drive(1'b1, RA'(d), Q'(d));
      tick();
    end
    idle_inputs();
    tests++;
    if ({bus.wr_req, bus.oCount, bus.oSquash} !== {1'b1, 3'd3, 8'd1}) begin
      fails++;
      $display("FAIL pre_reset: req=%b count=%0d squash=%0d, required 1 3 1",
               bus.wr_req, bus.oCount, bus.oSquash);
    end
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if ({bus.wr_req, bus.oCount, bus.oOvf, bus.oSquash, bus.oReady} !==
        {1'b0, 3'd0, 1'b0, 8'd0, 1'b1}) begin
      fails++;
      $display("FAIL async_reset: req=%b count=%0d ovf=%b squash=%0d ready=%b, required 0 0 0 0 1",
               bus.wr_req, bus.oCount, bus.oOvf, bus.oSquash, bus.oReady);
    end
    sb.delete();
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_basic();
    test_squash();
    test_fill_overflow();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    check_sb_empty("final_sb");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
